rf_wb_queue: RTL

RF_WB_QUEUE -- requirements
Module: rf_wb_queue

---
 rtl/rf_wb_queue.sv | 96 +++++++++
 1 files changed

// File: rtl/rf_wb_queue.sv
// Register-file writeback queue: a circular FIFO of pending {reg, data} writes
// that drains into one register-file write port and forwards pending values to decode.
module rf_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_reg,
    input  logic [31:0]              in_data,
    input  logic                     drain_en,
    output logic                     rf_regwrite,
    output logic [4:0]               rf_write_reg,
    output logic [31:0]              rf_write_data,
    input  logic [4:0]               rs,
    input  logic [4:0]               rt,
    output logic                     fwd_rs_hit,
    output logic                     fwd_rt_hit,
    output logic [31:0]              fwd_rs_data,
    output logic [31:0]              fwd_rt_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [4:0]    r_reg  [DEPTH];
    logic [31:0]   r_data [DEPTH];

    logic w_push;
    logic w_pop;

    // Writes to register 0 are consumed by the handshake but never stored.
    assign in_ready    = (r_count < FULL);
    assign w_push      = in_valid && in_ready && (in_reg != 5'd0);
    assign w_pop       = drain_en && (r_count != '0);
    assign rf_regwrite = w_pop;
    assign count       = r_count;

    assign rf_write_reg  = w_pop ? r_reg[r_head]  : 5'd0;
    assign rf_write_data = w_pop ? r_data[r_head] : 32'd0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the entry array has no reset; validity comes solely from head/count,
    // so stale contents are never observable and the storage can map to plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_reg[r_tail]  <= in_reg;
            r_data[r_tail] <= in_data;
        end
    end

    // Scan oldest to newest so the last match, the newest entry, wins.
    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        fwd_rs_hit  = 1'b0;
        fwd_rt_hit  = 1'b0;
        fwd_rs_data = 32'd0;
        fwd_rt_data = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < r_count) begin
                if (rs != 5'd0 && r_reg[r_head + PW'(i)] == rs) begin
                    fwd_rs_hit  = 1'b1;
                    fwd_rs_data = r_data[r_head + PW'(i)];
                end
                if (rt != 5'd0 && r_reg[r_head + PW'(i)] == rt) begin
                    fwd_rt_hit  = 1'b1;
                    fwd_rt_data = r_data[r_head + PW'(i)];
                end
            end
        end
    end

endmodule
